// File: rtl/ahb_slave_ctrl.sv
// ahb_slave_ctrl
//   AHB-Lite slave transfer controller for the USB endpoint register and
//   data-buffer block. Captures the address phase, classifies each transfer
//   as legal/illegal and sequences the data phase (OKAY, buffer wait states,
//   or a two-cycle ERROR response). Emits one-cycle access strobes.
//
// Parameters
//   MAX_WAIT   consecutive buf_busy cycles tolerated before ERROR (1..255)
//
// Ports
//   clk, n_rst                 clock, asynchronous active-low reset
//   hsel, htrans, hwrite,      AHB address-phase inputs
//   haddr, hsize
//   buf_busy                   data buffer cannot service the access now
//   hready, hresp              HREADYOUT / HRESP
//   haddr_reg, hsize_reg,      registered address phase, to the decoder
//   hwrite_reg
//   data_phase                 current cycle is an OKAY-completing data phase
//   buf_read, buf_write        buffer pop / push strobes
//   reg_write                  write strobe for 0xC / 0xD
//   err_addr, err_sticky       only with AHB_SLAVE_ERR_CAPTURE_EN defined:
//                              address of the last ERROR and a sticky flag,
//                              cleared by a legal write to 0xD
module ahb_slave_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       hsel,
  input  logic [1:0] htrans,
  input  logic       hwrite,
  input  logic [3:0] haddr,
  input  logic [1:0] hsize,
  input  logic       buf_busy,
  output logic       hready,
  output logic       hresp,
  output logic [3:0] haddr_reg,
  output logic [1:0] hsize_reg,
  output logic       hwrite_reg,
  output logic       data_phase,
  output logic       buf_read,
  output logic       buf_write,
  output logic       reg_write
`ifdef AHB_SLAVE_ERR_CAPTURE_EN
  ,
  output logic [3:0] err_addr,
  output logic       err_sticky
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_BUF,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       legal;
  logic       accept;
  logic       buf_wait;
  logic       buf_done;
  logic       timeout;

  // Legality of the transfer currently on the address-phase inputs.
  always_comb begin
    legal = 1'b0;
    if (hsize != 2'd3) begin
      if (haddr[3:2] == 2'b00) begin
        legal = (hsize == 2'd0) ||
                (hsize == 2'd1 && !haddr[0]) ||
                (hsize == 2'd2 && haddr[1:0] == 2'b00);
      end else if (haddr[3:2] == 2'b01) begin
        legal = !hwrite && ((hsize == 2'd0) || (hsize == 2'd1 && !haddr[0]));
      end else if (haddr == 4'h8) begin
        legal = !hwrite && (hsize == 2'd0);
      end else if (haddr == 4'hC || haddr == 4'hD) begin
        legal = (hsize == 2'd0);
      end
    end
  end

  // Buffer completion must be visible in the same cycle buf_busy drops,
  // so the BUF-state outputs combine the state register with buf_busy;
  // every other output is a pure decode of registered state.
  assign buf_wait   = (state == S_BUF) && buf_busy;
  assign buf_done   = (state == S_BUF) && !buf_busy;
  assign timeout    = buf_wait && (wait_cnt == 8'(MAX_WAIT - 1));

  assign hready     = !(buf_wait || state == S_ERR1);
  assign hresp      = (state == S_ERR1) || (state == S_ERR2);
  assign data_phase = (state == S_DATA) || buf_done;
  assign buf_read   = buf_done && !hwrite_reg;
  assign buf_write  = buf_done && hwrite_reg;
  assign reg_write  = (state == S_DATA) && hwrite_reg && (haddr_reg[3:1] == 3'b110);

  // NONSEQ (10) or SEQ (11) only.
  assign accept     = hsel && (htrans == 2'b10 || htrans == 2'b11) && hready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      haddr_reg  <= '0;
      hsize_reg  <= '0;
      hwrite_reg <= 1'b0;
    end else if (accept) begin
      haddr_reg  <= haddr;
      hsize_reg  <= hsize;
      hwrite_reg <= hwrite;
      wait_cnt   <= '0;
      if (!legal)
        state <= S_ERR1;
      else if (haddr[3:2] == 2'b00)
        state <= S_BUF;
      else
        state <= S_DATA;
    end else if (buf_wait) begin
      if (timeout) begin
        state    <= S_ERR1;
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end else if (state == S_ERR1) begin
      state <= S_ERR2;
    end else begin
      // hready=1 with nothing accepted: data phase finished, bus idles.
      state    <= S_IDLE;
      wait_cnt <= '0;
    end
  end

`ifdef AHB_SLAVE_ERR_CAPTURE_EN
  // An illegal accept enters ERR1 on the same edge that loads haddr_reg,
  // so the address is taken from the bus rather than the stale register.
  // Entering ERR1 takes priority over a coincident clearing write.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_addr   <= '0;
      err_sticky <= 1'b0;
    end else if (accept && !legal) begin
      err_addr   <= haddr;
      err_sticky <= 1'b1;
    end else if (timeout) begin
      err_addr   <= haddr_reg;
      err_sticky <= 1'b1;
    end else if (reg_write && haddr_reg == 4'hD) begin
      err_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ahb_slave_ctrl.sv
// tb_ahb_slave_ctrl
//   Self-checking bench for ahb_slave_ctrl (MAX_WAIT overridden to 4).
//   A transfer-level reference model predicts every output each cycle;
//   directed sequences are followed by randomized traffic.
//   Honours AHB_SLAVE_ERR_CAPTURE_EN when defined.
module tb_ahb_slave_ctrl;

  localparam int unsigned MW = 4;

  localparam int K_IDLE = 0;
  localparam int K_REG  = 1;
  localparam int K_BUF  = 2;
  localparam int K_ERR1 = 3;
  localparam int K_ERR2 = 4;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       hsel;
  logic [1:0] htrans;
  logic       hwrite;
  logic [3:0] haddr;
  logic [1:0] hsize;
  logic       buf_busy;
  logic       hready;
  logic       hresp;
  logic [3:0] haddr_reg;
  logic [1:0] hsize_reg;
  logic       hwrite_reg;
  logic       data_phase;
  logic       buf_read;
  logic       buf_write;
  logic       reg_write;
`ifdef AHB_SLAVE_ERR_CAPTURE_EN
  logic [3:0] err_addr;
  logic       err_sticky;
`endif

  always #5 clk = ~clk;

  ahb_slave_ctrl #(.MAX_WAIT(MW)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .hsel       (hsel),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .haddr      (haddr),
    .hsize      (hsize),
    .buf_busy   (buf_busy),
    .hready     (hready),
    .hresp      (hresp),
    .haddr_reg  (haddr_reg),
    .hsize_reg  (hsize_reg),
    .hwrite_reg (hwrite_reg),
    .data_phase (data_phase),
    .buf_read   (buf_read),
    .buf_write  (buf_write),
    .reg_write  (reg_write)
`ifdef AHB_SLAVE_ERR_CAPTURE_EN
    ,
    .err_addr   (err_addr),
    .err_sticky (err_sticky)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the pending transfer is, and how long it has waited.
  int       m_kind;
  int       m_waited;
  bit [3:0] m_addr;
  bit [1:0] m_size;
  bit       m_wr;
  bit [3:0] m_err_addr;
  bit       m_sticky;

  function automatic bit legal_ref(input int a, input int sz, input bit wr);
    int bytes;
    if (sz == 3) return 1'b0;
    bytes = 1 << sz;
    if (a % bytes != 0) return 1'b0;
    if (a < 4) return 1'b1;
    if (a < 8) return !wr && bytes <= 2;
    if (a == 8) return !wr && bytes == 1;
    if (a == 12 || a == 13) return bytes == 1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_kind     = K_IDLE;
    m_waited   = 0;
    m_addr     = '0;
    m_size     = '0;
    m_wr       = 1'b0;
    m_err_addr = '0;
    m_sticky   = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hready"}, hready, 1);
    check({tag, "_hresp"}, hresp, 0);
    check({tag, "_dphase"}, data_phase, 0);
    check({tag, "_strobes"}, {buf_read, buf_write, reg_write}, 0);
    check({tag, "_regs"}, {haddr_reg, hsize_reg, hwrite_reg}, 0);
`ifdef AHB_SLAVE_ERR_CAPTURE_EN
    check({tag, "_erracc"}, {err_addr, err_sticky}, 0);
`endif
  endtask

  // One bus cycle: drive inputs after the falling edge, check every output
  // against the model, then advance the model across the next rising edge.
  task automatic cycle(input bit sel, input logic [1:0] tr, input bit wr,
                       input logic [3:0] a, input logic [1:0] sz, input bit busy);
    bit e_rdy, e_resp, e_dp, e_br, e_bw, e_rw, acc;
    @(negedge clk);
    hsel = sel; htrans = tr; hwrite = wr; haddr = a; hsize = sz; buf_busy = busy;
    #1;
    e_rdy = 1; e_resp = 0; e_dp = 0; e_br = 0; e_bw = 0; e_rw = 0;
    case (m_kind)
      K_REG: begin
        e_dp = 1;
        e_rw = m_wr && (m_addr == 4'hC || m_addr == 4'hD);
      end
      K_BUF: begin
        if (busy) e_rdy = 0;
        else begin
          e_dp = 1;
          e_br = !m_wr;
          e_bw = m_wr;
        end
      end
      K_ERR1: begin e_rdy = 0; e_resp = 1; end
      K_ERR2: e_resp = 1;
      default: ;
    endcase
    check("hready", hready, e_rdy);
    check("hresp", hresp, e_resp);
    check("data_phase", data_phase, e_dp);
    check("buf_read", buf_read, e_br);
    check("buf_write", buf_write, e_bw);
    check("reg_write", reg_write, e_rw);
    check("haddr_reg", haddr_reg, m_addr);
    check("hsize_reg", hsize_reg, m_size);
    check("hwrite_reg", hwrite_reg, m_wr);
`ifdef AHB_SLAVE_ERR_CAPTURE_EN
    check("err_addr", err_addr, m_err_addr);
    check("err_sticky", err_sticky, m_sticky);
`endif
    acc = sel && tr[1] && e_rdy;
    if (e_rw && m_addr == 4'hD) m_sticky = 0;
    if (acc) begin
      m_addr = a; m_size = sz; m_wr = wr; m_waited = 0;
      if (legal_ref(int'(a), int'(sz), wr)) m_kind = (a < 4) ? K_BUF : K_REG;
      else begin
        m_kind = K_ERR1; m_err_addr = a; m_sticky = 1;
      end
    end else if (m_kind == K_BUF && busy) begin
      m_waited++;
      if (m_waited == int'(MW)) begin
        m_kind = K_ERR1; m_err_addr = m_addr; m_sticky = 1; m_waited = 0;
      end
    end else if (m_kind == K_ERR1) begin
      m_kind = K_ERR2;
    end else begin
      m_kind = K_IDLE;
    end
  endtask

  task automatic idle_cycle(input bit busy);
    cycle(0, 2'b00, 0, 4'h0, 2'd0, busy);
  endtask

  // Assert reset between edges, check it takes effect at once, release later.
  task automatic reset_mid(input string tag);
    #1 n_rst = 1'b0;
    #1;
    check_reset_values(tag);
    model_reset();
    @(posedge clk);
    #2 n_rst = 1'b1;
  endtask

  initial begin
    int n_wait, n_err1, n_err2, n_strobe;
    bit [3:0] ill_a [3];
    bit [1:0] ill_s [3];
    bit       ill_w [3];

    n_rst = 1'b0;
    hsel = 0; htrans = 0; hwrite = 0; haddr = 0; hsize = 0; buf_busy = 0;
    model_reset();
    #3;
    check_reset_values("rst");
    @(posedge clk);
    #2 n_rst = 1'b1;

    // Byte write to tx_control, then IDLE.
    cycle(1, 2'b10, 1, 4'hC, 2'd0, 0);
    idle_cycle(0);
    check("t1_rw", reg_write, 1);
    check("t1_addr", haddr_reg, 4'hC);
    check("t1_rdy", {hready, hresp, data_phase}, 3'b101);
    idle_cycle(0);
    check("t1_rw_width", reg_write, 0);

    // Word read of the buffer, busy for 3 cycles (one short of the timeout).
    cycle(1, 2'b10, 0, 4'h0, 2'd2, 0);
    n_wait = 0;
    for (int i = 0; i < 3; i++) begin
      idle_cycle(1);
      if (hready === 1'b0 && hresp === 1'b0) n_wait++;
    end
    check("t2_waits", n_wait, 3);
    idle_cycle(0);
    check("t2_done", {hready, hresp, buf_read}, 3'b101);
    idle_cycle(0);
    check("t2_rd_width", buf_read, 0);

    // Word read with buf_busy stuck: MW waits, ERR1, ERR2, no strobe.
    cycle(1, 2'b10, 0, 4'h0, 2'd2, 0);
    n_wait = 0; n_err1 = 0; n_err2 = 0; n_strobe = 0;
    for (int i = 0; i < 7; i++) begin
      idle_cycle(1);
      if (hready === 1'b0 && hresp === 1'b0) n_wait++;
      if (hready === 1'b0 && hresp === 1'b1) n_err1++;
      if (hready === 1'b1 && hresp === 1'b1) n_err2++;
      if (buf_read || buf_write || reg_write || data_phase) n_strobe++;
    end
    check("t3_waits", n_wait, MW);
    check("t3_err1", n_err1, 1);
    check("t3_err2", n_err2, 1);
    check("t3_nostrobe", n_strobe, 0);

    // Illegal accesses: write to status, misaligned half, unmapped byte.
    ill_a = '{4'h4, 4'h1, 4'hA};
    ill_s = '{2'd0, 2'd1, 2'd0};
    ill_w = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      cycle(1, 2'b10, ill_w[i], ill_a[i], ill_s[i], 0);
      idle_cycle(0);
      check("t4_err1", {hready, hresp, data_phase, buf_read, buf_write, reg_write}, 6'b010000);
      idle_cycle(0);
      check("t4_err2", {hready, hresp, data_phase, buf_read, buf_write, reg_write}, 6'b110000);
`ifdef AHB_SLAVE_ERR_CAPTURE_EN
      check("t4_erraddr", err_addr, ill_a[i]);
      check("t4_sticky", err_sticky, 1);
`endif
    end
`ifdef AHB_SLAVE_ERR_CAPTURE_EN
    cycle(1, 2'b10, 1, 4'hD, 2'd0, 0);
    idle_cycle(0);
    idle_cycle(0);
    check("t4_sticky_clr", err_sticky, 0);
`endif

    // Back-to-back byte reads of occupancy, status, error.
    cycle(1, 2'b10, 0, 4'h8, 2'd0, 0);
    cycle(1, 2'b10, 0, 4'h4, 2'd0, 0);
    check("t5_a", {hready, data_phase, haddr_reg}, {2'b11, 4'h8});
    cycle(1, 2'b11, 0, 4'h6, 2'd0, 0);
    check("t5_b", {hready, data_phase, haddr_reg}, {2'b11, 4'h4});
    idle_cycle(0);
    check("t5_c", {hready, data_phase, haddr_reg}, {2'b11, 4'h6});

    // Reset during a buffer write wait.
    cycle(1, 2'b10, 1, 4'h0, 2'd2, 0);
    idle_cycle(1);
    check("t6_waiting", hready, 0);
    reset_mid("t6");
    idle_cycle(1);
    check("t6_idle", {hready, hresp, buf_write}, 3'b100);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit       r_sel, r_wr, r_busy;
      bit [1:0] r_tr, r_sz;
      bit [3:0] r_a;
      r_sel  = $urandom_range(0, 9) != 0;
      r_tr   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      r_wr   = 1'($urandom_range(0, 1));
      r_a    = 4'($urandom_range(0, 15));
      r_sz   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_busy = 1'($urandom_range(0, 1));
      cycle(r_sel, r_tr, r_wr, r_a, r_sz, r_busy);
      if ($urandom_range(0, 299) == 0) reset_mid("rnd_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_slave_ctrl.md
Name: ahb_slave_ctrl

Overview:
- AHB-Lite slave transfer controller for the USB endpoint register and data-buffer block.
- Captures the address phase and registers HADDR/HSIZE/HWRITE for the downstream address decoder.
- Classifies each transfer as legal or illegal and sequences its data phase: OKAY completion, buffer wait states, or a two-cycle ERROR response.
- Emits single-cycle access strobes to the data buffer and the control registers.

Parameters:
- MAX_WAIT, 15: maximum consecutive wait cycles on a buffer access before the controller forces an ERROR response (legal range 1..255).

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- hsel  in  1  slave select
- htrans  in  2  AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- hwrite  in  1  1 = write
- haddr  in  4  byte address
- hsize  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- buf_busy  in  1  data buffer cannot service the access this cycle
- hready  out  1  HREADYOUT
- hresp  out  1  1 = ERROR
- haddr_reg  out  4  registered address phase, to the decoder
- hsize_reg  out  2  registered size
- hwrite_reg  out  1  registered direction
- data_phase  out  1  current cycle is an OKAY-completing data phase
- buf_read  out  1  pop strobe for buffer reads
- buf_write  out  1  push strobe for buffer writes
- reg_write  out  1  write strobe for 0xC/0xD

Behaviour:
- Interface: one clock, clk; asynchronous active-low reset, n_rst.
- Reset values: hready=1, hresp=0, all strobes=0, data_phase=0, haddr_reg/hsize_reg/hwrite_reg=0, wait counter=0, state=IDLE.
- Address phase accept: at a rising edge where hsel && htrans[1] && hready. On accept, haddr/hsize/hwrite are registered.
- IDLE/BUSY transfers, or hsel=0: nothing is accepted. The next cycle is IDLE with hready=1 and hresp=0.
- Legality (checked on the sampled values):
  - 0x0-0x3 buffer, RW: byte at any address; half requires haddr[0]=0; word requires haddr[1:0]=0.
  - 0x4-0x5 status and 0x6-0x7 error, RO: byte at any address; half at 0x4 or 0x6 only; word is illegal.
  - 0x8 occupancy, RO: byte only.
  - 0xC tx_control and 0xD flush, RW: byte only.
  - Everything else is illegal: 0x9-0xB, 0xE-0xF, hsize=3, any write to an RO address, any misalignment.
- States:
  - IDLE: no data phase pending.
  - DATA: legal register access. hready=1, data_phase=1. reg_write=1 if the access is a write to 0xC/0xD. Completes in 1 cycle.
  - BUF: legal buffer access.
    - buf_busy=0: hready=1, data_phase=1, buf_read or buf_write=1 per direction. Completes in the same cycle.
    - buf_busy=1: hready=0 and the wait counter increments.
    - Counter reaches MAX_WAIT while buf_busy=1: go to ERR1 with no strobe.
  - ERR1: hready=0, hresp=1.
  - ERR2: hready=1, hresp=1.
  - Illegal transfer: goes directly to ERR1, then ERR2. It never asserts data_phase or any strobe.
- Pipelining:
  - Any cycle with hready=1 (DATA, BUF completion, ERR2, IDLE) also samples the next address phase.
  - Back-to-back transfers therefore complete one per cycle with zero added latency.
- Wait counter clears on every accept and whenever the state leaves BUF.
- Strobes are exactly 1 cycle wide, at most one strobe per transfer.
- haddr_reg, hsize_reg and hwrite_reg hold until the next accept.
- Reset mid-transfer (any state): return to reset values immediately. The pending transfer is dropped with no strobe.
- buf_busy toggling in the same cycle the counter hits MAX_WAIT: a sampled buf_busy=0 wins, and the transfer completes OKAY.

Optional Feature:
- Macro: AHB_SLAVE_ERR_CAPTURE_EN.
- When defined:
  - Adds outputs err_addr[3:0] and err_sticky.
  - On entry to ERR1: err_addr <= haddr_reg and err_sticky <= 1.
  - err_sticky clears on a completed legal write to 0xD (reg_write with haddr_reg=0xD).
  - Both reset to 0.
- When undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Byte write to 0xC, htrans=10, followed by IDLE -> the next cycle has hready=1, hresp=0, data_phase=1, reg_write=1 for exactly 1 cycle, haddr_reg=0xC.
- Word read at 0x0 with buf_busy=1 for 3 cycles, then 0 -> hready=0 for 3 cycles, then hready=1 with buf_read=1 for 1 cycle. Counter peaks at 3; no error.
- Word read at 0x0 with buf_busy held at 1 and MAX_WAIT=4 -> 4 wait cycles, then ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1). buf_read never asserted.
- Illegal accesses: write to 0x4, half access at 0x1, byte access at 0xA -> each produces ERR1 followed by ERR2, with no strobes. With AHB_SLAVE_ERR_CAPTURE_EN defined, err_addr=0x4, 0x1, 0xA respectively and err_sticky=1.
- Back-to-back NONSEQ byte reads of 0x8, 0x4, 0x6 -> three consecutive data_phase=1 cycles, hready held at 1, haddr_reg updating each cycle.
- n_rst asserted during the BUF wait of a word write -> hready=1, hresp=0, buf_write=0 immediately. After release, the controller sits in IDLE.
